multicycle_controller: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control unit. A five-state FSM sequences each instruction through IF/ID/EX/MEM/WB and stalls on a variable-latency memory via a `mem_ready` handshake. It keeps the existing datapath select encodings and ALU_OP codes, and adds a memory-timeout watchdog and illegal-instruction trapping. It sits between the instruction register (which supplies OP/func) and the shared multi-cycle datapath.

---
 rtl/multicycle_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing with a mem_ready
// handshake, a memory watchdog and illegal-instruction trapping.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       ZF,
  input  logic       mem_ready,
  output logic       Mem_Req,
  output logic       IorD,
  output logic       Mem_Write,
  output logic       IR_Write,
  output logic       PC_Write,
  output logic [1:0] PC_s,
  output logic [1:0] w_r_s,
  output logic [1:0] wr_data_s,
  output logic       imm_s,
  output logic       rt_imm_s,
  output logic [2:0] ALU_OP,
  output logic       Write_Reg,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] LP_TIMEOUT = TO_W'(MEM_TIMEOUT);

  state_t          r_state;
  logic [TO_W-1:0] r_cnt;
  logic            r_illegal;
  logic            r_timeout;

  logic       w_legal;
  logic       w_isR;
  logic       w_isJ;
  logic       w_isJal;
  logic       w_isJr;
  logic       w_isBeq;
  logic       w_isBne;
  logic       w_isLw;
  logic       w_isSw;
  logic [2:0] w_aluOp;
  logic       w_immS;
  logic       w_rtImmS;
  logic       w_wdExpired;
  logic       w_taken;

  // Instruction decode, shared by the ID/EX/MEM/WB output logic.
  always_comb begin
    w_legal  = 1'b0;
    w_isR    = 1'b0;
    w_isJ    = 1'b0;
    w_isJal  = 1'b0;
    w_isJr   = 1'b0;
    w_isBeq  = 1'b0;
    w_isBne  = 1'b0;
    w_isLw   = 1'b0;
    w_isSw   = 1'b0;
    w_aluOp  = 3'b100;
    w_immS   = 1'b0;
    w_rtImmS = 1'b0;
    case (OP)
      6'b000000: begin
        w_isR   = 1'b1;
        w_legal = 1'b1;
        case (func)
          6'b100000: w_aluOp = 3'b100;
          6'b100010: w_aluOp = 3'b101;
          6'b100100: w_aluOp = 3'b000;
          6'b100101: w_aluOp = 3'b001;
          6'b100110: w_aluOp = 3'b010;
          6'b100111: w_aluOp = 3'b011;
          6'b101011: w_aluOp = 3'b110;
          6'b000100: w_aluOp = 3'b111;
          6'b001000: w_isJr  = 1'b1;
          default:   w_legal = 1'b0;
        endcase
      end
      6'b001000: begin w_legal = 1'b1; w_aluOp = 3'b100; w_immS = 1'b1; w_rtImmS = 1'b1; end
      6'b001100: begin w_legal = 1'b1; w_aluOp = 3'b000; w_rtImmS = 1'b1; end
      6'b001110: begin w_legal = 1'b1; w_aluOp = 3'b010; w_rtImmS = 1'b1; end
      6'b001011: begin w_legal = 1'b1; w_aluOp = 3'b110; w_rtImmS = 1'b1; end
      6'b100011: begin w_legal = 1'b1; w_isLw = 1'b1; w_immS = 1'b1; w_rtImmS = 1'b1; end
      6'b101011: begin w_legal = 1'b1; w_isSw = 1'b1; w_immS = 1'b1; w_rtImmS = 1'b1; end
      6'b000100: begin w_legal = 1'b1; w_isBeq = 1'b1; w_aluOp = 3'b101; w_immS = 1'b1; end
      6'b000101: begin w_legal = 1'b1; w_isBne = 1'b1; w_aluOp = 3'b101; w_immS = 1'b1; end
      6'b000010: begin w_legal = 1'b1; w_isJ = 1'b1; end
      6'b000011: begin w_legal = 1'b1; w_isJal = 1'b1; end
      default:   w_legal = 1'b0;
    endcase
  end

  // A ready response in the same cycle as the limit wins over the watchdog.
  assign w_wdExpired = (MEM_TIMEOUT != 0) && (r_cnt == LP_TIMEOUT);
  assign w_taken     = (w_isBeq && ZF) || (w_isBne && !ZF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IF;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_IF: begin
          if (mem_ready) begin
            r_state <= S_ID;
          end else if (w_wdExpired) begin
            r_state   <= S_ERR;
            r_timeout <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        S_ID: begin
          if (!w_legal) begin
            r_state   <= S_ERR;
            r_illegal <= 1'b1;
          end else if (w_isJ || w_isJal || w_isJr) begin
            r_state <= S_IF;
          end else begin
            r_state <= S_EX;
          end
        end
        S_EX: begin
          if (w_isBeq || w_isBne)     r_state <= S_IF;
          else if (w_isLw || w_isSw)  r_state <= S_MEM;
          else                        r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= w_isLw ? S_WB : S_IF;
          end else if (w_wdExpired) begin
            r_state   <= S_ERR;
            r_timeout <= 1'b1;
          end else if (MEM_TIMEOUT != 0) begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        S_WB:    r_state <= S_IF;
        default: r_state <= S_ERR;
      endcase
    end
  end

  // Control outputs are decoded from the current state; reset forces them all low.
  always_comb begin
    Mem_Req   = 1'b0;
    IorD      = 1'b0;
    Mem_Write = 1'b0;
    IR_Write  = 1'b0;
    PC_Write  = 1'b0;
    PC_s      = 2'b00;
    w_r_s     = 2'b00;
    wr_data_s = 2'b00;
    imm_s     = 1'b0;
    rt_imm_s  = 1'b0;
    ALU_OP    = 3'b000;
    Write_Reg = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IF: begin
          Mem_Req = 1'b1;
          if (mem_ready) begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
          end
        end
        S_ID: begin
          if (w_isJ || w_isJal) begin
            PC_Write = 1'b1;
            PC_s     = 2'b11;
          end
          if (w_isJal) begin
            Write_Reg = 1'b1;
            w_r_s     = 2'b10;
            wr_data_s = 2'b10;
          end
          if (w_isJr) begin
            PC_Write = 1'b1;
            PC_s     = 2'b01;
          end
        end
        S_EX: begin
          ALU_OP   = w_aluOp;
          imm_s    = w_immS;
          rt_imm_s = w_rtImmS;
          if (w_taken) begin
            PC_Write = 1'b1;
            PC_s     = 2'b10;
          end
        end
        S_MEM: begin
          Mem_Req   = 1'b1;
          IorD      = 1'b1;
          Mem_Write = w_isSw;
          ALU_OP    = 3'b100;
          imm_s     = 1'b1;
          rt_imm_s  = 1'b1;
        end
        S_WB: begin
          Write_Reg = 1'b1;
          w_r_s     = w_isR ? 2'b00 : 2'b01;
          wr_data_s = w_isLw ? 2'b01 : 2'b00;
          ALU_OP    = w_aluOp;
          imm_s     = w_immS;
          rt_imm_s  = w_rtImmS;
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-scenario tasks with
// hand-computed state sequences and control values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OP;
  logic [5:0] func;
  logic       ZF;
  logic       mem_ready;
  logic       Mem_Req, IorD, Mem_Write, IR_Write, PC_Write;
  logic [1:0] PC_s, w_r_s, wr_data_s;
  logic       imm_s, rt_imm_s;
  logic [2:0] ALU_OP;
  logic       Write_Reg;
  logic [2:0] state;
  logic       illegal, timeout;

  int nCompared   = 0;
  int nMismatched = 0;

  multicycle_controller #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .func(func), .ZF(ZF), .mem_ready(mem_ready),
    .Mem_Req(Mem_Req), .IorD(IorD), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .PC_Write(PC_Write), .PC_s(PC_s), .w_r_s(w_r_s), .wr_data_s(wr_data_s),
    .imm_s(imm_s), .rt_imm_s(rt_imm_s), .ALU_OP(ALU_OP), .Write_Reg(Write_Reg),
    .state(state), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; OP = 6'd0; func = 6'b100000; ZF = 1'b0;
    step();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL reset_state got %0d want 0", state); end
    nCompared++;
    if ({illegal, timeout} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_flags got %b want 00", {illegal, timeout}); end
    nCompared++;
    if ({Mem_Req, Mem_Write, IR_Write, PC_Write, Write_Reg} !== 5'b0) begin
      nMismatched++; $display("[TB] FAIL reset_strobes got %b want 00000", {Mem_Req, Mem_Write, IR_Write, PC_Write, Write_Reg});
    end
    rst_n = 1'b1;
    #1;
    nCompared++;
    if ({Mem_Req, IorD, IR_Write} !== 3'b101) begin
      nMismatched++; $display("[TB] FAIL if_after_reset got %b want 101", {Mem_Req, IorD, IR_Write});
    end
  endtask

  task automatic test_add;
    logic [2:0] expState [5];
    expState = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    OP = 6'b000000; func = 6'b100000; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      nCompared++;
      if (state !== expState[c]) begin nMismatched++; $display("[TB] FAIL add_state[%0d] got %0d want %0d", c, state, expState[c]); end
      nCompared++;
      if (Write_Reg !== (c == 3)) begin nMismatched++; $display("[TB] FAIL add_wr[%0d] got %b want %b", c, Write_Reg, (c == 3)); end
      if (c == 2 || c == 3) begin
        nCompared++;
        if ({ALU_OP, rt_imm_s} !== 4'b1000) begin nMismatched++; $display("[TB] FAIL add_alu[%0d] got %b want 1000", c, {ALU_OP, rt_imm_s}); end
      end
      if (c == 3) begin
        nCompared++;
        if ({w_r_s, wr_data_s} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL add_wb_sel got %b want 0000", {w_r_s, wr_data_s}); end
      end
      if (c < 4) step();
    end
  endtask

  task automatic test_reset_mid;
    OP = 6'b000000; func = 6'b100010; mem_ready = 1'b1;
    step(); step(); step();
    nCompared++;
    if (state !== 3'd4) begin nMismatched++; $display("[TB] FAIL mid_pre_state got %0d want 4", state); end
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({Write_Reg, ALU_OP} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mid_forced got %b want 0000", {Write_Reg, ALU_OP}); end
    step();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL mid_state got %0d want 0", state); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_lw_wait;
    int cycles = 0;
    OP = 6'b100011; func = 6'd0; mem_ready = 1'b1;
    step(); cycles++;
    step(); cycles++;
    nCompared++;
    if ({state, ALU_OP, imm_s, rt_imm_s} !== {3'd2, 3'b100, 2'b11}) begin
      nMismatched++; $display("[TB] FAIL lw_ex got %b want 01010011", {state, ALU_OP, imm_s, rt_imm_s});
    end
    mem_ready = 1'b0;
    step(); cycles++;
    for (int m = 0; m < 4; m++) begin
      if (m == 3) mem_ready = 1'b1;
      #1;
      nCompared++;
      if ({state, Mem_Req, IorD, Mem_Write} !== {3'd3, 3'b110}) begin
        nMismatched++; $display("[TB] FAIL lw_mem[%0d] got %b want 011110", m, {state, Mem_Req, IorD, Mem_Write});
      end
      step(); cycles++;
    end
    nCompared++;
    if ({state, Write_Reg, wr_data_s, w_r_s} !== {3'd4, 1'b1, 2'b01, 2'b01}) begin
      nMismatched++; $display("[TB] FAIL lw_wb got %b want 10010101", {state, Write_Reg, wr_data_s, w_r_s});
    end
    step(); cycles++;
    nCompared++;
    if (state !== 3'd0 || cycles != 8) begin nMismatched++; $display("[TB] FAIL lw_latency got state %0d cycles %0d want 0/8", state, cycles); end
  endtask

  task automatic test_sw;
    OP = 6'b101011; mem_ready = 1'b1;
    step(); step(); step();
    nCompared++;
    if ({state, Mem_Req, IorD, Mem_Write} !== {3'd3, 3'b111}) begin
      nMismatched++; $display("[TB] FAIL sw_mem got %b want 011111", {state, Mem_Req, IorD, Mem_Write});
    end
    step();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL sw_latency got %0d want 0", state); end
  endtask

  task automatic test_branch;
    logic [5:0] opTab [4];
    logic       zfTab [4];
    logic       tkTab [4];
    opTab = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    zfTab = '{1'b1, 1'b0, 1'b0, 1'b1};
    tkTab = '{1'b1, 1'b0, 1'b1, 1'b0};
    mem_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      OP = opTab[b]; ZF = zfTab[b];
      step(); step();
      nCompared++;
      if ({state, ALU_OP} !== {3'd2, 3'b101}) begin nMismatched++; $display("[TB] FAIL br_ex[%0d] got %b want 010101", b, {state, ALU_OP}); end
      nCompared++;
      if ({PC_Write, PC_s} !== (tkTab[b] ? 3'b110 : 3'b000)) begin
        nMismatched++; $display("[TB] FAIL br_pc[%0d] got %b want %b", b, {PC_Write, PC_s}, (tkTab[b] ? 3'b110 : 3'b000));
      end
      step();
      nCompared++;
      if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL br_latency[%0d] got %0d want 0", b, state); end
    end
    ZF = 1'b0;
  endtask

  task automatic test_jumps;
    mem_ready = 1'b1;
    OP = 6'b000011;
    step();
    nCompared++;
    if ({state, PC_Write, PC_s, Write_Reg, w_r_s, wr_data_s} !== {3'd1, 1'b1, 2'b11, 1'b1, 2'b10, 2'b10}) begin
      nMismatched++; $display("[TB] FAIL jal_id got %b want 0011111 1010", {state, PC_Write, PC_s, Write_Reg, w_r_s, wr_data_s});
    end
    step();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL jal_latency got %0d want 0", state); end
    OP = 6'b000010;
    step();
    nCompared++;
    if ({PC_Write, PC_s, Write_Reg} !== 4'b1110) begin nMismatched++; $display("[TB] FAIL j_id got %b want 1110", {PC_Write, PC_s, Write_Reg}); end
    step();
    OP = 6'b000000; func = 6'b001000;
    step();
    nCompared++;
    if ({PC_Write, PC_s, Write_Reg} !== 4'b1010) begin nMismatched++; $display("[TB] FAIL jr_id got %b want 1010", {PC_Write, PC_s, Write_Reg}); end
    step();
    nCompared++;
    if (state !== 3'd0) begin nMismatched++; $display("[TB] FAIL jr_latency got %0d want 0", state); end
  endtask

  task automatic test_illegal;
    OP = 6'b111111; mem_ready = 1'b1;
    step();
    nCompared++;
    if ({state, illegal} !== {3'd1, 1'b0}) begin nMismatched++; $display("[TB] FAIL ill_id got %b want 0010", {state, illegal}); end
    step();
    for (int k = 0; k < 10; k++) begin
      mem_ready = k[0];
      #1;
      nCompared++;
      if ({state, illegal, Mem_Req, Mem_Write, IR_Write, PC_Write, Write_Reg} !== {3'd7, 1'b1, 5'b0}) begin
        nMismatched++; $display("[TB] FAIL ill_err[%0d] got %b want 111100000", k, {state, illegal, Mem_Req, Mem_Write, IR_Write, PC_Write, Write_Reg});
      end
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    nCompared++;
    if ({state, illegal} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL ill_reset got %b want 0000", {state, illegal}); end
    OP = 6'b000000; func = 6'b111111; mem_ready = 1'b1;
    step(); step();
    nCompared++;
    if ({state, illegal} !== {3'd7, 1'b1}) begin nMismatched++; $display("[TB] FAIL ill_func got %b want 1111", {state, illegal}); end
  endtask

  task automatic test_timeout;
    rst_n = 1'b0; mem_ready = 1'b0; OP = 6'b000000; func = 6'b100000;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      nCompared++;
      if ({state, Mem_Req} !== {3'd0, 1'b1}) begin nMismatched++; $display("[TB] FAIL to_if[%0d] got %b want 0001", i, {state, Mem_Req}); end
      step();
    end
    nCompared++;
    if ({state, timeout, illegal} !== {3'd7, 2'b10}) begin nMismatched++; $display("[TB] FAIL to_err got %b want 11110", {state, timeout, illegal}); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    nCompared++;
    if ({state, timeout} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL to_reset got %b want 0000", {state, timeout}); end
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) mem_ready = 1'b1;
      #1;
      if (i == 16) begin
        nCompared++;
        if ({state, IR_Write} !== {3'd0, 1'b1}) begin nMismatched++; $display("[TB] FAIL to_edge got %b want 0001", {state, IR_Write}); end
      end
      step();
    end
    nCompared++;
    if ({state, timeout} !== {3'd1, 1'b0}) begin nMismatched++; $display("[TB] FAIL to_boundary got %b want 0010", {state, timeout}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_mid();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jumps();
    test_illegal();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
